// File: rtl/fmlarb4_pkg.sv
// Shared constants and types for the four-master FML arbiter.
package fmlarb4_pkg;

    localparam int FML_BURST_LEN   = 4;
    localparam int FMLARB_NMASTERS = 4;
    localparam int FMLARB_IDX_W    = 2;

    typedef logic [FMLARB_IDX_W-1:0] midx_t;

    // Beat counter load value for one write burst
    localparam logic [2:0] WCNT_LOAD = 3'(FML_BURST_LEN);

    // Master index arithmetic wraps modulo the number of masters
    function automatic midx_t idx_add(input midx_t base, input int ofs);
        return midx_t'(base + ofs[FMLARB_IDX_W-1:0]);
    endfunction

endpackage

// File: rtl/fmlarb_pick.sv
// Combinational grant selection. Fixed priority (m0 highest) by default;
// with FMLARB_RR_EN defined the search starts one past the last grant, so
// the last grantee is eligible but ranked lowest.
module fmlarb_pick
    import fmlarb4_pkg::*;
(
    input  logic [3:0] req,
    input  midx_t      last,
    output midx_t      next,
    output logic       found
);

    midx_t cand_s;

    // Scan candidates from lowest to highest priority; the last hit wins
    always_comb begin
        next   = last;
        found  = 1'b0;
        cand_s = last;
`ifdef FMLARB_RR_EN
        for (int i = FMLARB_NMASTERS; i >= 1; i--) begin
            cand_s = idx_add(last, i);
            next   = req[cand_s] ? cand_s : next;
            found  = found | req[cand_s];
        end
`else
        for (int i = FMLARB_NMASTERS - 1; i >= 0; i--) begin
            cand_s = midx_t'(i);
            next   = req[cand_s] ? cand_s : next;
            found  = found | req[cand_s];
        end
`endif
    end

endmodule

// File: rtl/fmlarb4.sv
// Four-master arbiter in front of the FML 4x64 SDRAM port.
// Optional build macro: FMLARB_RR_EN selects round-robin instead of fixed
// priority (only fmlarb_pick is affected).
module fmlarb4
    import fmlarb4_pkg::*;
#(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [fml_depth-1:0] m0_adr,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    output logic                 m0_eack,
    input  logic [7:0]           m0_sel,
    input  logic [63:0]          m0_di,
    output logic [63:0]          m0_do,
    input  logic [fml_depth-1:0] m1_adr,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    output logic                 m1_eack,
    input  logic [7:0]           m1_sel,
    input  logic [63:0]          m1_di,
    output logic [63:0]          m1_do,
    input  logic [fml_depth-1:0] m2_adr,
    input  logic                 m2_stb,
    input  logic                 m2_we,
    output logic                 m2_eack,
    input  logic [7:0]           m2_sel,
    input  logic [63:0]          m2_di,
    output logic [63:0]          m2_do,
    input  logic [fml_depth-1:0] m3_adr,
    input  logic                 m3_stb,
    input  logic                 m3_we,
    output logic                 m3_eack,
    input  logic [7:0]           m3_sel,
    input  logic [63:0]          m3_di,
    output logic [63:0]          m3_do,
    output logic [fml_depth-1:0] s_adr,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [7:0]           s_sel,
    output logic [63:0]          s_di,
    input  logic                 s_eack,
    input  logic [63:0]          s_do
);

    logic [fml_depth-1:0] adr_s [FMLARB_NMASTERS];
    logic [7:0]           sel_s [FMLARB_NMASTERS];
    logic [63:0]          di_s  [FMLARB_NMASTERS];
    logic [3:0]           stb_s;
    logic [3:0]           we_s;

    midx_t      gnt_r;
    logic       gnt_v_r;
    midx_t      wm_r;
    logic [2:0] wcnt_r;

    midx_t                next_s;
    logic                 found_s;
    logic                 rearb_s;
    logic                 burst_act_s;
    logic [fml_depth-1:0] s_adr_s;
    logic                 s_we_s;
    logic [7:0]           s_sel_s;
    logic [63:0]          s_di_s;

    assign adr_s[0] = m0_adr;
    assign adr_s[1] = m1_adr;
    assign adr_s[2] = m2_adr;
    assign adr_s[3] = m3_adr;
    assign sel_s[0] = m0_sel;
    assign sel_s[1] = m1_sel;
    assign sel_s[2] = m2_sel;
    assign sel_s[3] = m3_sel;
    assign di_s[0]  = m0_di;
    assign di_s[1]  = m1_di;
    assign di_s[2]  = m2_di;
    assign di_s[3]  = m3_di;
    assign stb_s    = {m3_stb, m2_stb, m1_stb, m0_stb};
    assign we_s     = {m3_we, m2_we, m1_we, m0_we};

    // Re-arbitrate when idle, when the owner has let go, or on acknowledge
    assign rearb_s     = ~gnt_v_r | ~stb_s[gnt_r] | s_eack;
    assign burst_act_s = (wcnt_r != 3'd0);

    fmlarb_pick u_pick (
        .req   (stb_s),
        .last  (gnt_r),
        .next  (next_s),
        .found (found_s)
    );

    // Grant register: hold the owner until its request is acknowledged
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gnt_r   <= 2'd0;
            gnt_v_r <= 1'b0;
        end else if (rearb_s) begin
            gnt_v_r <= found_s;
            gnt_r   <= found_s ? next_s : gnt_r;
        end else begin
            gnt_r   <= gnt_r;
            gnt_v_r <= gnt_v_r;
        end
    end

    // Write burst tracker: remember the acknowledged writer, count its beats
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wm_r   <= 2'd0;
            wcnt_r <= 3'd0;
        end else if (s_eack && s_we_s) begin
            wm_r   <= gnt_r;
            wcnt_r <= WCNT_LOAD;
        end else if (burst_act_s) begin
            wcnt_r <= wcnt_r - 3'd1;
        end else begin
            wcnt_r <= wcnt_r;
        end
    end

    // Address-phase multiplexer follows the current grant
    always_comb begin
        s_adr_s = {fml_depth{1'b0}};
        s_we_s  = 1'b0;
        if (gnt_v_r) begin
            s_adr_s = adr_s[gnt_r];
            s_we_s  = we_s[gnt_r];
        end else begin
            s_adr_s = {fml_depth{1'b0}};
            s_we_s  = 1'b0;
        end
    end

    // Write data steering follows the burst owner, not the current grant
    always_comb begin
        s_sel_s = 8'd0;
        s_di_s  = 64'd0;
        if (burst_act_s) begin
            s_sel_s = sel_s[wm_r];
            s_di_s  = di_s[wm_r];
        end else begin
            s_sel_s = 8'd0;
            s_di_s  = 64'd0;
        end
    end

    // Strobe is held off during a write burst so bursts never overlap
    assign s_stb = gnt_v_r & stb_s[gnt_r] & ~burst_act_s;
    assign s_adr = s_adr_s;
    assign s_we  = s_we_s;
    assign s_sel = s_sel_s;
    assign s_di  = s_di_s;

    assign m0_eack = s_eack & gnt_v_r & (gnt_r == 2'd0);
    assign m1_eack = s_eack & gnt_v_r & (gnt_r == 2'd1);
    assign m2_eack = s_eack & gnt_v_r & (gnt_r == 2'd2);
    assign m3_eack = s_eack & gnt_v_r & (gnt_r == 2'd3);

    assign m0_do = s_do;
    assign m1_do = s_do;
    assign m2_do = s_do;
    assign m3_do = s_do;

endmodule

// File: tb/tb_fmlarb4.sv
// Randomized bench for fmlarb4 with a scoreboard: stimulus pushes expected
// acknowledges and write beats, a negedge monitor pops and compares.
module tb_fmlarb4;

    localparam int DEPTH  = 26;
    localparam int NCYC   = 3000;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n;
    logic [DEPTH-1:0] m_adr [4];
    logic [3:0]       m_stb;
    logic [3:0]       m_we;
    logic [7:0]       m_sel [4];
    logic [63:0]      m_di  [4];
    wire  [3:0]       m_eack;
    wire  [63:0]      m_do  [4];
    wire  [DEPTH-1:0] s_adr;
    wire              s_stb;
    wire              s_we;
    wire  [7:0]       s_sel;
    wire  [63:0]      s_di;
    logic             s_eack;
    logic [63:0]      s_do;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          own  = 0;
    bit          ownv = 1'b0;
    logic [3:0]  eack_q [$];
    logic [63:0] beat_d_q [$];
    logic [7:0]  beat_s_q [$];

    // Master and slave bench state
    int          burst_left [4];
    logic [63:0] wdat [4][4];
    logic [7:0]  wsel [4][4];
    int          swait = 0;
    int          slat  = 2;

    fmlarb4 #(.fml_depth(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m0_adr(m_adr[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_eack(m_eack[0]),
        .m0_sel(m_sel[0]), .m0_di(m_di[0]), .m0_do(m_do[0]),
        .m1_adr(m_adr[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_eack(m_eack[1]),
        .m1_sel(m_sel[1]), .m1_di(m_di[1]), .m1_do(m_do[1]),
        .m2_adr(m_adr[2]), .m2_stb(m_stb[2]), .m2_we(m_we[2]), .m2_eack(m_eack[2]),
        .m2_sel(m_sel[2]), .m2_di(m_di[2]), .m2_do(m_do[2]),
        .m3_adr(m_adr[3]), .m3_stb(m_stb[3]), .m3_we(m_we[3]), .m3_eack(m_eack[3]),
        .m3_sel(m_sel[3]), .m3_di(m_di[3]), .m3_do(m_do[3]),
        .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_di(s_di),
        .s_eack(s_eack), .s_do(s_do)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arbitration rule from the specification, evaluated over the request set
    task automatic model_pick(input logic [3:0] req);
        int chosen = -1;
`ifdef FMLARB_RR_EN
        for (int k = 1; k <= 4; k++)
            if (chosen < 0 && req[(own + k) % 4]) chosen = (own + k) % 4;
`else
        for (int k = 0; k < 4; k++)
            if (chosen < 0 && req[k]) chosen = k;
`endif
        if (chosen < 0) ownv = 1'b0;
        else begin
            own  = chosen;
            ownv = 1'b1;
        end
    endtask

    task automatic model_reset();
        own  = 0;
        ownv = 1'b0;
        eack_q.delete();
        beat_d_q.delete();
        beat_s_q.delete();
    endtask

    // Monitor: compare DUT outputs against the model away from the clock edge
    initial begin
        logic [3:0]  exp_ev;
        logic [63:0] exp_d;
        logic [7:0]  exp_s;
        forever begin
            @(negedge sys_clk);
            chk("s_stb", s_stb, ownv && m_stb[own] && (beat_d_q.size() == 0));
            chk("s_adr", s_adr, ownv ? m_adr[own] : '0);
            chk("s_we",  s_we,  ownv ? m_we[own] : 1'b0);
            if (m_eack != 4'd0 || eack_q.size() > 0) begin
                exp_ev = (eack_q.size() > 0) ? eack_q.pop_front() : 4'd0;
                chk("eack", m_eack, exp_ev);
            end
            if (s_sel != 8'd0 || beat_d_q.size() > 0) begin
                exp_d = 64'd0;
                exp_s = 8'd0;
                if (beat_d_q.size() > 0) begin
                    exp_d = beat_d_q.pop_front();
                    exp_s = beat_s_q.pop_front();
                end
                chk("s_sel", s_sel, exp_s);
                chk("s_di",  s_di,  exp_d);
            end else begin
                chk("s_di_idle", s_di, 64'd0);
            end
            for (int i = 0; i < 4; i++) chk("m_do", m_do[i], s_do);
        end
    end

    // Stimulus: masters, slave responder and model update, one pass per cycle
    initial begin
        logic [3:0] prev_req;
        bit         prev_eack;
        bit         rst_prev;
        bit         did_mid;
        bit         do_rst;
        int         eo;
        sys_rst_n = 1'b0;
        m_stb = 4'd0;
        m_we  = 4'd0;
        s_eack = 1'b0;
        s_do   = 64'd0;
        for (int m = 0; m < 4; m++) begin
            m_adr[m] = '0;
            m_sel[m] = 8'd0;
            m_di[m]  = 64'd0;
            burst_left[m] = 0;
        end
        prev_req = 4'd0;
        prev_eack = 1'b0;
        rst_prev = 1'b1;
        did_mid = 1'b0;
        repeat (3) @(posedge sys_clk);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge sys_clk);
            #1;
            if (rst_prev) begin
                model_reset();
                m_stb = 4'd0;
                for (int m = 0; m < 4; m++) burst_left[m] = 0;
                swait = 0;
                sys_rst_n = 1'b1;
                rst_prev = 1'b0;
            end else begin
                eo = own;
                if (prev_eack && ownv) begin
                    eack_done(eo);
                end
                if (!ownv || !prev_req[own] || prev_eack) model_pick(prev_req);
            end

            do_rst = (!did_mid && beat_d_q.size() == 3) || ($urandom_range(0, 299) == 0);
            if (do_rst) begin
                // Reset mid-cycle with requests and an acknowledge still present
                if (beat_d_q.size() == 3) did_mid = 1'b1;
                sys_rst_n = 1'b0;
                model_reset();
                s_eack = 1'b1;
                swait = 0;
                rst_prev = 1'b1;
            end else begin
                for (int m = 0; m < 4; m++) begin
                    if (burst_left[m] > 0) begin
                        m_di[m]  = wdat[m][4 - burst_left[m]];
                        m_sel[m] = wsel[m][4 - burst_left[m]];
                        burst_left[m]--;
                    end else begin
                        m_di[m]  = {$urandom, $urandom};
                        m_sel[m] = 8'($urandom);
                        if (!m_stb[m]) begin
                            m_adr[m] = DEPTH'($urandom);
                            m_we[m]  = 1'($urandom);
                            if ($urandom_range(0, (m == 0) ? 1 : 3) == 0) begin
                                m_stb[m] = 1'b1;
                                for (int b = 0; b < 4; b++) begin
                                    wdat[m][b] = {$urandom, $urandom};
                                    wsel[m][b] = 8'($urandom_range(1, 255));
                                end
                            end
                        end
                    end
                end
                s_eack = (swait >= slat);
                if (s_eack && ownv) eack_q.push_back(4'b0001 << own);
            end
            s_do = {$urandom, $urandom};
            prev_req = m_stb;
            prev_eack = s_eack;
            @(negedge sys_clk);
            if (s_eack) begin
                swait = 0;
                slat = $urandom_range(1, 3);
            end else if (s_stb) begin
                swait++;
            end else begin
                swait = 0;
            end
        end
        @(posedge sys_clk);
        #1;
        chk("mid_burst_reset_seen", {127'd0, did_mid}, 128'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Acknowledged master drops its request; a write starts its data burst
    task automatic eack_done(input int eo);
        m_stb[eo] = 1'b0;
        if (m_we[eo]) begin
            for (int b = 0; b < 4; b++) begin
                beat_d_q.push_back(wdat[eo][b]);
                beat_s_q.push_back(wsel[eo][b]);
            end
            burst_left[eo] = 4;
        end
    endtask

endmodule
